dcache_write_buffer: RTL and testbench



---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_line_fifo.sv | 87 ++++++++
 rtl/dcache_write_buffer.sv | 165 ++++++++++++++++
 tb/tb_dcache_write_buffer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the data-cache write buffer: FSM state encoding,
// bus constants and the line-offset helper.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD    = 2'd1,
        ST_WADDR = 2'd2,
        ST_WDATA = 2'd3
    } wb_state_t;

    localparam int         LINE_WORDS_DEF = 8;
    localparam int         LINE_OFF       = $clog2(LINE_WORDS_DEF) + 2;
    localparam logic [2:0] D_SIZE_WORD    = 3'b010;
    localparam logic [3:0] BE_FULL        = 4'b1111;

    // Number of byte-offset bits inside one line of lw 32-bit words.
    function automatic int line_off_bits(input int lw);
        return $clog2(lw) + 2;
    endfunction

endpackage

// File: rtl/wb_line_fifo.sv
// Line FIFO for the write buffer: address flops, line storage with registered word
// read, pointers/count, and the parallel refill-address hazard compare.
module wb_line_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int LINE_WORDS = 8,
    parameter int AW         = 32,
    localparam int PW        = $clog2(DEPTH),
    localparam int BW        = $clog2(LINE_WORDS)
) (
    input  logic                       clk,
    input  logic                       rset,
    input  logic                       push_en,
    input  logic                       coalesce_allow,
    input  logic                       over_en,
    input  logic [AW-1:0]              push_addr,
    input  logic [32*LINE_WORDS-1:0]   push_data,
    input  logic                       pop_en,
    input  logic [AW-1:0]              rf_addr,
    input  logic [BW-1:0]              beat_sel,
    output logic [PW:0]                count,
    output logic [AW-1:0]              head_addr,
    output logic [31:0]                head_word,
    output logic                       hit,
    output logic                       coalesce
);

    localparam int            OFF       = line_off_bits(LINE_WORDS);
    localparam logic [AW-1:0] LINE_MASK = ~((AW'(1) << OFF) - AW'(1));

    logic [AW-1:0]             addr_reg [DEPTH];
    logic [32*LINE_WORDS-1:0]  line_mem [DEPTH];
    logic [PW-1:0]             rd_ptr_reg;
    logic [PW-1:0]             wr_ptr_reg;
    logic [PW:0]               count_reg;
    logic [31:0]               head_word_reg;
    logic [PW-1:0]             tail_ptr;
    logic [PW-1:0]             mem_wr_idx;
    logic [DEPTH-1:0]          hit_vec;

    assign tail_ptr   = wr_ptr_reg - PW'(1);
    assign mem_wr_idx = push_en ? wr_ptr_reg : tail_ptr;

    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_reg[i] <= '0;
            end
        end else begin
            if (push_en) begin
                addr_reg[wr_ptr_reg] <= push_addr & LINE_MASK;
                wr_ptr_reg           <= wr_ptr_reg + PW'(1);
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_reg + (PW+1)'(push_en) - (PW+1)'(pop_en);
        end
    end

    // Line data lives in a plain array (no reset) so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (push_en || over_en) begin
            line_mem[mem_wr_idx] <= push_data;
        end
        head_word_reg <= line_mem[rd_ptr_reg][{beat_sel, 5'd0} +: 32];
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        logic [PW-1:0] slot_off;
        assign slot_off    = PW'(gi) - rd_ptr_reg;
        assign hit_vec[gi] = ({1'b0, slot_off} < count_reg) &&
                             (addr_reg[gi] == (rf_addr & LINE_MASK));
    end

    assign hit       = |hit_vec;
    assign coalesce  = coalesce_allow && (count_reg != '0) &&
                       (addr_reg[tail_ptr] == (push_addr & LINE_MASK));
    assign count     = count_reg;
    assign head_addr = (count_reg != '0) ? addr_reg[rd_ptr_reg] : '0;
    assign head_word = head_word_reg;

endmodule

// File: rtl/dcache_write_buffer.sv
// Data-cache write buffer: queues evicted lines, drains them as INCR write bursts and
// arbitrates the shared d-side address bus with refill reads. Optional: WB_COALESCE_EN.
module dcache_write_buffer
    import wb_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int LINE_WORDS = 8,
    parameter int AW         = 32
) (
    input  logic                      clk,
    input  logic                      rset,
    input  logic                      wb_push_valid,
    output logic                      wb_push_ready,
    input  logic [AW-1:0]             wb_push_addr,
    input  logic [32*LINE_WORDS-1:0]  wb_push_data,
    input  logic                      rf_req,
    input  logic [AW-1:0]             rf_addr,
    output logic                      rf_grant,
    output logic                      rf_done,
    output logic                      wb_empty,
    output logic [AW-1:0]             d_addr,
    output logic                      d_addr_valid,
    output logic                      d_we,
    output logic [2:0]                d_size,
    output logic [7:0]                d_lens,
    output logic [31:0]               d_wr_data,
    output logic                      d_wr_valid,
    output logic [3:0]                d_byte_enable,
    output logic                      d_wr_wlast,
    input  logic                      d_valid_clear,
    input  logic                      d_wr_next,
    input  logic                      d_wr_finish,
    input  logic                      d_rd_dready,
    input  logic                      d_rlast
);

    localparam int PW = $clog2(DEPTH);
    localparam int BW = $clog2(LINE_WORDS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

    wb_state_t      state_reg;
    logic [BW-1:0]  beat_reg;
    logic [BW-1:0]  beat_next;
    logic           rd_acc_reg;
    logic           rf_done_reg;

    logic [PW:0]    count;
    logic [AW-1:0]  head_addr;
    logic [31:0]    head_word;
    logic           hit;
    logic           coalesce;
    logic           coalesce_allow;
    logic           draining;
    logic           pop;
    logic           alloc;
    logic           over;
    logic           full;

    assign draining = (state_reg == ST_WADDR) || (state_reg == ST_WDATA);
    assign full     = (count == (PW+1)'(DEPTH));
    assign pop      = (state_reg == ST_WDATA) && d_wr_finish;

`ifdef WB_COALESCE_EN
    // The head line is already on the bus once draining starts, so it cannot be rewritten.
    assign coalesce_allow = !(draining && (count == (PW+1)'(1)));
`else
    assign coalesce_allow = 1'b0;
`endif

    assign wb_push_ready = !full || pop || coalesce;
    assign alloc         = wb_push_valid && wb_push_ready && !coalesce;
    assign over          = wb_push_valid && coalesce;

    wb_line_fifo #(
        .DEPTH      (DEPTH),
        .LINE_WORDS (LINE_WORDS),
        .AW         (AW)
    ) u_fifo (
        .clk            (clk),
        .rset           (rset),
        .push_en        (alloc),
        .coalesce_allow (coalesce_allow),
        .over_en        (over),
        .push_addr      (wb_push_addr),
        .push_data      (wb_push_data),
        .pop_en         (pop),
        .rf_addr        (rf_addr),
        .beat_sel       (beat_next),
        .count          (count),
        .head_addr      (head_addr),
        .head_word      (head_word),
        .hit            (hit),
        .coalesce       (coalesce)
    );

    // beat_next also addresses the registered word read, so data tracks the beat.
    always_comb begin
        beat_next = beat_reg;
        if ((state_reg == ST_WADDR) && d_valid_clear) begin
            beat_next = '0;
        end else if ((state_reg == ST_WDATA) && d_wr_next && !d_wr_finish &&
                     (beat_reg != LAST_BEAT)) begin
            beat_next = beat_reg + BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            state_reg   <= ST_IDLE;
            beat_reg    <= '0;
            rd_acc_reg  <= 1'b0;
            rf_done_reg <= 1'b0;
        end else begin
            rf_done_reg <= 1'b0;
            beat_reg    <= beat_next;
            case (state_reg)
                ST_IDLE: begin
                    // rf_req is still high while rf_done shows; don't restart that refill.
                    if (full) begin
                        state_reg <= ST_WADDR;
                    end else if (rf_req && !hit && !rf_done_reg) begin
                        state_reg  <= ST_RD;
                        rd_acc_reg <= 1'b0;
                    end else if (count != '0) begin
                        state_reg <= ST_WADDR;
                    end
                end
                ST_RD: begin
                    if (d_valid_clear) begin
                        rd_acc_reg <= 1'b1;
                    end
                    if (d_rd_dready && d_rlast) begin
                        rf_done_reg <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end
                end
                ST_WADDR: begin
                    if (d_valid_clear) begin
                        state_reg <= ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (d_wr_finish) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign rf_grant      = (state_reg == ST_RD);
    assign rf_done       = rf_done_reg;
    assign wb_empty      = (count == '0) && !draining;
    assign d_addr        = rf_grant ? rf_addr : head_addr;
    assign d_we          = !rf_grant && (count != '0);
    assign d_addr_valid  = (state_reg == ST_WADDR) || (rf_grant && !rd_acc_reg);
    assign d_size        = D_SIZE_WORD;
    assign d_lens        = 8'(LINE_WORDS - 1);
    assign d_byte_enable = BE_FULL;
    assign d_wr_valid    = (state_reg == ST_WDATA);
    assign d_wr_data     = d_wr_valid ? head_word : 32'd0;
    assign d_wr_wlast    = d_wr_valid && (beat_reg == LAST_BEAT);

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer: a vector table for a single-line burst plus
// hand-written sequences for full FIFO, refill bypass, hazard, async reset and coalescing.
module tb_dcache_write_buffer;

    localparam int AW = 32;
    localparam int LW = 8;

    logic             clk = 1'b0;
    logic             rset;
    logic             wb_push_valid;
    logic             wb_push_ready;
    logic [AW-1:0]    wb_push_addr;
    logic [32*LW-1:0] wb_push_data;
    logic             rf_req;
    logic [AW-1:0]    rf_addr;
    logic             rf_grant;
    logic             rf_done;
    logic             wb_empty;
    logic [AW-1:0]    d_addr;
    logic             d_addr_valid;
    logic             d_we;
    logic [2:0]       d_size;
    logic [7:0]       d_lens;
    logic [31:0]      d_wr_data;
    logic             d_wr_valid;
    logic [3:0]       d_byte_enable;
    logic             d_wr_wlast;
    logic             d_valid_clear;
    logic             d_wr_next;
    logic             d_wr_finish;
    logic             d_rd_dready;
    logic             d_rlast;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dcache_write_buffer #(.DEPTH(2), .LINE_WORDS(LW), .AW(AW)) dut (
        .clk           (clk),
        .rset          (rset),
        .wb_push_valid (wb_push_valid),
        .wb_push_ready (wb_push_ready),
        .wb_push_addr  (wb_push_addr),
        .wb_push_data  (wb_push_data),
        .rf_req        (rf_req),
        .rf_addr       (rf_addr),
        .rf_grant      (rf_grant),
        .rf_done       (rf_done),
        .wb_empty      (wb_empty),
        .d_addr        (d_addr),
        .d_addr_valid  (d_addr_valid),
        .d_we          (d_we),
        .d_size        (d_size),
        .d_lens        (d_lens),
        .d_wr_data     (d_wr_data),
        .d_wr_valid    (d_wr_valid),
        .d_byte_enable (d_byte_enable),
        .d_wr_wlast    (d_wr_wlast),
        .d_valid_clear (d_valid_clear),
        .d_wr_next     (d_wr_next),
        .d_wr_finish   (d_wr_finish),
        .d_rd_dready   (d_rd_dready),
        .d_rlast       (d_rlast)
    );

    typedef struct {
        logic        pv;
        logic [31:0] pa;
        logic        vc;
        logic        nx;
        logic        fin;
        logic        e_av;
        logic        e_we;
        logic        e_wv;
        logic        e_wl;
        logic        e_emp;
        logic        e_rdy;
        logic [31:0] e_addr;
        logic [31:0] e_data;
    } vec_t;

    localparam int NV = 21;
    vec_t vt [NV];

    function automatic logic [32*LW-1:0] make_line(input logic [31:0] base);
        logic [32*LW-1:0] l;
        for (int k = 0; k < LW; k++) l[32*k +: 32] = base + 32'(k);
        return l;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Drains one write burst; the bus accepts each beat immediately.
    task automatic drain_line(input logic [31:0] addr, input logic [31:0] base,
                              output logic fin_ready, output logic grant_seen);
        int n;
        n = 0;
        grant_seen = 1'b0;
        fin_ready = 1'b0;
        #1;
        while (!(d_addr_valid === 1'b1 && d_we === 1'b1) && n < 40) begin
            grant_seen |= rf_grant;
            tick();
            #1;
            n++;
        end
        chk("waddr_wait", 64'(n < 40), 64'd1);
        chk("waddr_addr", 64'(d_addr), 64'(addr));
        d_valid_clear = 1'b1;
        tick();
        d_valid_clear = 1'b0;
        for (int k = 0; k < LW; k++) begin
            #1;
            chk($sformatf("burst_%0h_data%0d", addr, k), 64'(d_wr_data), 64'(base + 32'(k)));
            chk($sformatf("burst_%0h_wlast%0d", addr, k), 64'(d_wr_wlast), 64'(k == LW-1));
            grant_seen |= rf_grant;
            d_wr_next = 1'b1;
            if (k == LW-1) begin
                d_wr_finish = 1'b1;
                #1;
                fin_ready = wb_push_ready;
            end
            tick();
            d_wr_next   = 1'b0;
            d_wr_finish = 1'b0;
        end
        $display("burst addr=%0h base=%0h drained", addr, base);
    endtask

    // Performs one refill once granted; rf_req must already be high.
    task automatic refill(input logic [31:0] addr);
        int n;
        n = 0;
        #1;
        while (rf_grant !== 1'b1 && n < 40) begin
            tick();
            #1;
            n++;
        end
        chk("rd_grant_wait", 64'(n < 40), 64'd1);
        chk("rd_addr", 64'(d_addr), 64'(addr));
        chk("rd_we", 64'(d_we), 64'd0);
        chk("rd_addr_valid", 64'(d_addr_valid), 64'd1);
        d_valid_clear = 1'b1;
        tick();
        d_valid_clear = 1'b0;
        #1;
        chk("rd_addr_valid_drop", 64'(d_addr_valid), 64'd0);
        for (int k = 0; k < LW; k++) begin
            d_rd_dready = 1'b1;
            d_rlast     = (k == LW-1);
            #1;
            chk("rd_done_early", 64'(rf_done), 64'd0);
            tick();
        end
        d_rd_dready = 1'b0;
        d_rlast     = 1'b0;
        #1;
        chk("rd_done_pulse", 64'(rf_done), 64'd1);
        chk("rd_grant_released", 64'(rf_grant), 64'd0);
        rf_req = 1'b0;
        tick();
        #1;
        chk("rd_done_single", 64'(rf_done), 64'd0);
        $display("refill addr=%0h done", addr);
    endtask

    logic fin_ready, grant_seen;
    int   n;

    initial begin
        // Single-line burst, one-cycle gap before each beat acceptance.
        vt[0] = '{pv:1, pa:32'h1040, vc:0, nx:0, fin:0, e_av:0, e_we:0, e_wv:0,
                  e_wl:0, e_emp:1, e_rdy:1, e_addr:32'h0, e_data:32'h0};
        vt[1] = '{pv:0, pa:32'h0, vc:0, nx:0, fin:0, e_av:0, e_we:1, e_wv:0,
                  e_wl:0, e_emp:0, e_rdy:1, e_addr:32'h1040, e_data:32'h0};
        vt[2] = '{pv:0, pa:32'h0, vc:1, nx:0, fin:0, e_av:1, e_we:1, e_wv:0,
                  e_wl:0, e_emp:0, e_rdy:1, e_addr:32'h1040, e_data:32'h0};
        for (int k = 0; k < LW; k++) begin
            vt[3+2*k] = '{pv:0, pa:32'h0, vc:0, nx:0, fin:0, e_av:0, e_we:1, e_wv:1,
                          e_wl:(k == LW-1), e_emp:0, e_rdy:1, e_addr:32'h1040,
                          e_data:32'h11 + 32'(k)};
            vt[4+2*k] = '{pv:0, pa:32'h0, vc:0, nx:1, fin:(k == LW-1), e_av:0, e_we:1,
                          e_wv:1, e_wl:(k == LW-1), e_emp:0, e_rdy:1, e_addr:32'h1040,
                          e_data:32'h11 + 32'(k)};
        end
        vt[19] = '{pv:0, pa:32'h0, vc:0, nx:0, fin:0, e_av:0, e_we:0, e_wv:0,
                   e_wl:0, e_emp:1, e_rdy:1, e_addr:32'h0, e_data:32'h0};
        vt[20] = vt[19];

        rset = 1'b0;
        wb_push_valid = 1'b0; wb_push_addr = '0; wb_push_data = '0;
        rf_req = 1'b0; rf_addr = '0;
        d_valid_clear = 1'b0; d_wr_next = 1'b0; d_wr_finish = 1'b0;
        d_rd_dready = 1'b0; d_rlast = 1'b0;
        tick(); tick();
        #1;
        chk("rst_ready", 64'(wb_push_ready), 64'd1);
        chk("rst_empty", 64'(wb_empty), 64'd1);
        chk("rst_outs", 64'({rf_grant, rf_done, d_addr_valid, d_we, d_wr_valid, d_wr_wlast}), 64'd0);
        chk("rst_addr_data", 64'({d_addr, d_wr_data}), 64'd0);
        chk("const_fields", 64'({d_size, d_lens, d_byte_enable}), 64'({3'b010, 8'd7, 4'b1111}));
        rset = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            wb_push_valid = vt[i].pv;
            wb_push_addr  = vt[i].pa;
            wb_push_data  = make_line(32'h11);
            d_valid_clear = vt[i].vc;
            d_wr_next     = vt[i].nx;
            d_wr_finish   = vt[i].fin;
            #1;
            chk($sformatf("vec%0d_addr_valid", i), 64'(d_addr_valid), 64'(vt[i].e_av));
            chk($sformatf("vec%0d_we", i), 64'(d_we), 64'(vt[i].e_we));
            chk($sformatf("vec%0d_wr_valid", i), 64'(d_wr_valid), 64'(vt[i].e_wv));
            chk($sformatf("vec%0d_wlast", i), 64'(d_wr_wlast), 64'(vt[i].e_wl));
            chk($sformatf("vec%0d_empty", i), 64'(wb_empty), 64'(vt[i].e_emp));
            chk($sformatf("vec%0d_ready", i), 64'(wb_push_ready), 64'(vt[i].e_rdy));
            chk($sformatf("vec%0d_addr", i), 64'(d_addr), 64'(vt[i].e_addr));
            chk($sformatf("vec%0d_data", i), 64'(d_wr_data), 64'(vt[i].e_data));
            $display("vec %0d addr=%0h data=%0h av=%0b wv=%0b wl=%0b", i, d_addr,
                     d_wr_data, d_addr_valid, d_wr_valid, d_wr_wlast);
            tick();
        end
        wb_push_valid = 1'b0; d_valid_clear = 1'b0; d_wr_next = 1'b0; d_wr_finish = 1'b0;

        // Fill to DEPTH with no address acceptance; third push must wait.
        wb_push_valid = 1'b1; wb_push_addr = 32'h4000; wb_push_data = make_line(32'h41);
        tick();
        wb_push_addr = 32'h5000; wb_push_data = make_line(32'h51);
        tick();
        wb_push_addr = 32'h6000; wb_push_data = make_line(32'h61);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("full_not_ready", 64'(wb_push_ready), 64'd0);
            chk("full_addr_waiting", 64'({d_addr_valid, d_addr}), 64'({1'b1, 32'h4000}));
            tick();
        end
        drain_line(32'h4000, 32'h41, fin_ready, grant_seen);
        chk("full_ready_at_pop", 64'(fin_ready), 64'd1);
        wb_push_valid = 1'b0;
        #1;
        chk("full_after_pop_ready", 64'(wb_push_ready), 64'd0);
        drain_line(32'h5000, 32'h51, fin_ready, grant_seen);
        drain_line(32'h6000, 32'h61, fin_ready, grant_seen);
        #1;
        chk("full_seq_empty", 64'(wb_empty), 64'd1);

        // Refill of an unrelated line goes first, then the pending write drains.
        wb_push_valid = 1'b1; wb_push_addr = 32'h1040; wb_push_data = make_line(32'h11);
        rf_req = 1'b1; rf_addr = 32'h2000;
        tick();
        wb_push_valid = 1'b0;
        refill(32'h2000);
        drain_line(32'h1040, 32'h11, fin_ready, grant_seen);
        chk("bypass_write_after", 64'(wb_empty), 64'd1);

        // Refill hitting a pending line waits for that line's write to finish.
        wb_push_valid = 1'b1; wb_push_addr = 32'h1040; wb_push_data = make_line(32'h21);
        tick();
        wb_push_valid = 1'b0;
        rf_req = 1'b1; rf_addr = 32'h1040;
        drain_line(32'h1040, 32'h21, fin_ready, grant_seen);
        chk("hazard_no_grant", 64'(grant_seen), 64'd0);
        refill(32'h1040);

        // Asynchronous reset in the middle of a burst at beat 3.
        wb_push_valid = 1'b1; wb_push_addr = 32'h7000; wb_push_data = make_line(32'h71);
        tick();
        wb_push_valid = 1'b0;
        n = 0;
        #1;
        while (d_addr_valid !== 1'b1 && n < 40) begin
            tick();
            #1;
            n++;
        end
        chk("rst_seq_waddr_wait", 64'(n < 40), 64'd1);
        d_valid_clear = 1'b1;
        tick();
        d_valid_clear = 1'b0;
        for (int k = 0; k < 3; k++) begin
            d_wr_next = 1'b1;
            tick();
            d_wr_next = 1'b0;
        end
        #1;
        chk("rst_seq_beat3", 64'({d_wr_valid, d_wr_data}), 64'({1'b1, 32'h74}));
        rset = 1'b0;
        #1;
        chk("rst_async_wr_valid", 64'(d_wr_valid), 64'd0);
        chk("rst_async_empty", 64'({wb_empty, wb_push_ready}), 64'd3);
        chk("rst_async_addr", 64'({d_addr_valid, d_addr}), 64'd0);
        $display("async reset applied mid-burst");
        tick();
        rset = 1'b1;
        tick();
        #1;
        chk("rst_after_idle", 64'({d_addr_valid, wb_empty}), 64'd1);

        // Two pushes to the same line before draining.
        wb_push_valid = 1'b1; wb_push_addr = 32'h3000; wb_push_data = make_line(32'h31);
        tick();
        wb_push_data = make_line(32'h81);
        #1;
        chk("coal_second_ready", 64'(wb_push_ready), 64'd1);
        tick();
        wb_push_valid = 1'b0;
`ifdef WB_COALESCE_EN
        drain_line(32'h3000, 32'h81, fin_ready, grant_seen);
`else
        drain_line(32'h3000, 32'h31, fin_ready, grant_seen);
        drain_line(32'h3000, 32'h81, fin_ready, grant_seen);
`endif
        #1;
        chk("coal_final_empty", 64'(wb_empty), 64'd1);
        chk("coal_no_extra_burst", 64'(d_addr_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
